// File: rtl/rf_bypass_sb_if.sv
// Register-file port bundle: read/write/reserve selects from decode,
// read data, validity and error flags back from the register file.
interface rf_bypass_sb_if #(
    parameter int WIDTH = 16,
    parameter int SELW  = 3
);
    logic [SELW-1:0]  read1regsel;
    logic [SELW-1:0]  read2regsel;
    logic [SELW-1:0]  writeregsel;
    logic [SELW-1:0]  reservesel;
    logic [WIDTH-1:0] writedata;
    logic             write;
    logic             reserve;
    logic [WIDTH-1:0] read1data;
    logic [WIDTH-1:0] read2data;
    logic             read1valid;
    logic             read2valid;
    logic             err;

    modport master (
        output read1regsel, read2regsel, writeregsel, reservesel,
        output writedata, write, reserve,
        input  read1data, read2data, read1valid, read2valid, err
    );

    modport slave (
        input  read1regsel, read2regsel, writeregsel, reservesel,
        input  writedata, write, reserve,
        output read1data, read2data, read1valid, read2valid, err
    );
endinterface

// File: rtl/rf_bypass_sb.sv
// Parametrised 2R/1W register file with write bypass and pending scoreboard.
// Define RF_ZERO_REG_EN to hardwire register 0 to zero.
module rf_bypass_sb #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int SELW  = 3
) (
    input logic         clk,
    input logic         rst,
    rf_bypass_sb_if.slave bus
);
`ifdef RF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    localparam logic [SELW:0] LIM = (SELW+1)'(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [SELW-1:0]  rsel   [2];
    logic [WIDTH-1:0] rdata  [2];
    logic             rvalid [2];
    logic             wen;
    logic             ren;

    function automatic logic ok(input logic [SELW-1:0] s);
        return {1'b0, s} < LIM;
    endfunction

    assign rsel[0] = bus.read1regsel;
    assign rsel[1] = bus.read2regsel;

    // Zero-register writes/reserves are dropped before they reach state.
    assign wen = bus.write && ok(bus.writeregsel)
              && !(ZR && bus.writeregsel == '0);
    assign ren = bus.reserve && ok(bus.reservesel)
              && !(ZR && bus.reservesel == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            pend <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wen && bus.writeregsel == SELW'(i)) begin
                    regs[i] <= bus.writedata;
                    pend[i] <= 1'b0;
                end
                // A reserve in the same cycle supersedes the write's clear.
                if (ren && bus.reservesel == SELW'(i))
                    pend[i] <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p]  = '0;
            rvalid[p] = 1'b0;
            if (wen && bus.writeregsel == rsel[p]) begin
                rdata[p]  = bus.writedata;
                rvalid[p] = 1'b1;
            end else begin
                for (int i = 0; i < NREGS; i++) begin
                    if (rsel[p] == SELW'(i)) begin
                        if (ZR && i == 0) begin
                            rdata[p]  = '0;
                            rvalid[p] = 1'b1;
                        end else begin
                            rdata[p]  = regs[i];
                            rvalid[p] = !pend[i];
                        end
                    end
                end
            end
        end
    end

    assign bus.read1data  = rdata[0];
    assign bus.read2data  = rdata[1];
    assign bus.read1valid = rvalid[0];
    assign bus.read2valid = rvalid[1];

    always_comb begin
        bus.err = !ok(bus.read1regsel) || !ok(bus.read2regsel)
               || (bus.write && !ok(bus.writeregsel))
               || (bus.reserve && !ok(bus.reservesel));
`ifndef SYNTHESIS
        if ($isunknown({bus.read1regsel, bus.read2regsel,
                        bus.writeregsel, bus.reservesel}))
            bus.err = 1'b1;
`endif
    end
endmodule

// File: tb/tb_rf_bypass_sb.sv
// Bench for rf_bypass_sb (NREGS=6): directed plan steps then random traffic
// checked against an array model of registers and pending flags.
module tb_rf_bypass_sb;
    localparam int W = 16;
    localparam int N = 6;
    localparam int S = 3;
`ifdef RF_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [W-1:0] m_reg  [8];
    bit           m_pend [8];

    rf_bypass_sb_if #(.WIDTH(W), .SELW(S)) bus ();

    rf_bypass_sb #(.WIDTH(W), .NREGS(N), .SELW(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] exp_read(input int sel);
        if (sel >= N) return '0;
        if (ZR && sel == 0) return {1'b1, {W{1'b0}}};
        if (bus.write && int'(bus.writeregsel) == sel)
            return {1'b1, bus.writedata};
        return {!m_pend[sel], m_reg[sel]};
    endfunction

    task automatic set(input bit r, input bit w, input int ws,
                       input logic [W-1:0] wd, input bit rv, input int rs,
                       input int s1, input int s2);
        rst             = r;
        bus.write       = w;
        bus.writeregsel = S'(ws);
        bus.writedata   = wd;
        bus.reserve     = rv;
        bus.reservesel  = S'(rs);
        bus.read1regsel = S'(s1);
        bus.read2regsel = S'(s2);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [W:0] e1, e2;
        bit         ee;
        e1 = exp_read(int'(bus.read1regsel));
        e2 = exp_read(int'(bus.read2regsel));
        ee = int'(bus.read1regsel) >= N || int'(bus.read2regsel) >= N
          || (bus.write && int'(bus.writeregsel) >= N)
          || (bus.reserve && int'(bus.reservesel) >= N);
        chk({tag, ".d1"}, 32'(bus.read1data), 32'(e1[W-1:0]));
        chk({tag, ".v1"}, 32'(bus.read1valid), 32'(e1[W]));
        chk({tag, ".d2"}, 32'(bus.read2data), 32'(e2[W-1:0]));
        chk({tag, ".v2"}, 32'(bus.read2valid), 32'(e2[W]));
        chk({tag, ".err"}, 32'(bus.err), 32'(ee));
    endtask

    task automatic tick();
        int ws, rs;
        @(posedge clk);
        ws = int'(bus.writeregsel);
        rs = int'(bus.reservesel);
        if (rst) begin
            foreach (m_reg[i]) begin
                m_reg[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (bus.write && ws < N && !(ZR && ws == 0)) begin
                m_reg[ws]  = bus.writedata;
                m_pend[ws] = 1'b0;
            end
            if (bus.reserve && rs < N && !(ZR && rs == 0))
                m_pend[rs] = 1'b1;
        end
        #1;
    endtask

    initial begin
        set(1, 0, 0, '0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < N; i++) begin
            set(0, 0, 0, '0, 0, 0, i, (i + 1) % N);
            check_model("rstread");
            chk("rstread.d1c", 32'(bus.read1data), 32'h0);
            chk("rstread.v1c", 32'(bus.read1valid), 32'h1);
            chk("rstread.errc", 32'(bus.err), 32'h0);
        end

        set(0, 1, 3, 16'hBEEF, 0, 0, 1, 3);
        check_model("wr3");
        tick();
        set(0, 0, 0, '0, 0, 0, 3, 0);
        chk("rd3.beef", 32'(bus.read1data), 32'hBEEF);
        set(0, 1, 3, 16'h1234, 0, 0, 3, 3);
        chk("byp3.d1", 32'(bus.read1data), 32'h1234);
        chk("byp3.d2", 32'(bus.read2data), 32'h1234);
        check_model("byp3");
        tick();
        set(0, 0, 0, '0, 0, 0, 3, 0);
        chk("rd3.1234", 32'(bus.read1data), 32'h1234);

        set(0, 0, 0, '0, 1, 5, 0, 5);
        check_model("rsv5");
        tick();
        set(0, 0, 0, '0, 0, 0, 0, 5);
        chk("pend5.v2", 32'(bus.read2valid), 32'h0);
        set(0, 1, 5, 16'h00AA, 0, 0, 0, 5);
        chk("byp5.d2", 32'(bus.read2data), 32'h00AA);
        chk("byp5.v2", 32'(bus.read2valid), 32'h1);
        tick();
        set(0, 0, 0, '0, 0, 0, 0, 5);
        chk("clr5.v2", 32'(bus.read2valid), 32'h1);
        set(0, 1, 5, 16'h00AA, 1, 5, 0, 0);
        tick();
        set(0, 0, 0, '0, 0, 0, 0, 5);
        chk("rw5.v2", 32'(bus.read2valid), 32'h0);
        chk("rw5.d2", 32'(bus.read2data), 32'h00AA);

        set(0, 1, 7, 16'h1111, 0, 0, 6, 1);
        chk("oor.err", 32'(bus.err), 32'h1);
        chk("oor.d1", 32'(bus.read1data), 32'h0);
        chk("oor.v1", 32'(bus.read1valid), 32'h0);
        tick();
        for (int i = 0; i < N; i++) begin
            set(0, 0, 0, '0, 0, 0, i, 7 - i);
            check_model("oorafter");
        end

        set(0, 1, 2, 16'h7777, 1, 4, 0, 0);
        tick();
        set(1, 1, 2, 16'hFFFF, 1, 2, 2, 4);
        check_model("rstpri.pre");
        tick();
        set(0, 0, 0, '0, 0, 0, 2, 4);
        chk("rstpri.d1", 32'(bus.read1data), 32'h0);
        chk("rstpri.v1", 32'(bus.read1valid), 32'h1);
        chk("rstpri.v2", 32'(bus.read2valid), 32'h1);

`ifdef RF_ZERO_REG_EN
        set(0, 1, 0, 16'h5555, 1, 0, 0, 0);
        chk("zr.d1", 32'(bus.read1data), 32'h0);
        chk("zr.v1", 32'(bus.read1valid), 32'h1);
        chk("zr.err", 32'(bus.err), 32'h0);
        tick();
        set(0, 0, 0, '0, 0, 0, 0, 0);
        chk("zr.after", 32'(bus.read1data), 32'h0);
        chk("zr.vafter", 32'(bus.read1valid), 32'h1);
`endif

        for (int k = 0; k < 400; k++) begin
            set($urandom_range(0, 31) == 0, 1'($urandom),
                int'($urandom_range(0, 7)), W'($urandom),
                1'($urandom), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            check_model("rand");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
